tone_detector: RTL

//  Receive-side counterpart of the keyboard tone generator: measures the period of an incoming square wave
//  (1 MHz system clock) and identifies which of 14 notes (low 1-7, middle 1-7) is sounding.

---
 rtl/tone_pkg.sv | 58 +++++
 rtl/tone_period_meter.sv | 47 ++++
 rtl/tone_detector.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared constants for the tone detector: note count, nominal periods at 1 MHz,
// FSM state encoding and the 7-segment digit lookup.
package tone_pkg;

  localparam int NUM_NOTES = 14;
  localparam int NOTE_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACQ   = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  // Nominal period in clock cycles; 0..6 low octave, 7..13 middle octave.
  function automatic logic [15:0] nom_period(input logic [NOTE_W-1:0] idx);
    logic [15:0] p;
    case (idx)
      4'd0:    p = 16'd3817;
      4'd1:    p = 16'd3401;
      4'd2:    p = 16'd3030;
      4'd3:    p = 16'd2865;
      4'd4:    p = 16'd2551;
      4'd5:    p = 16'd2273;
      4'd6:    p = 16'd2024;
      4'd7:    p = 16'd1912;
      4'd8:    p = 16'd1704;
      4'd9:    p = 16'd1517;
      4'd10:   p = 16'd1433;
      4'd11:   p = 16'd1276;
      4'd12:   p = 16'd1136;
      4'd13:   p = 16'd1012;
      default: p = 16'd0;
    endcase
    return p;
  endfunction

  // {dp,g,f,e,d,c,b,a}; dp marks the middle octave.
  function automatic logic [7:0] seg_code(input logic [NOTE_W-1:0] idx);
    logic [NOTE_W-1:0] digit;
    logic [6:0]        segs;
    logic              mid;
    mid   = (idx >= 4'd7) && (idx < 4'd14);
    digit = (idx >= 4'd7) ? idx - 4'd7 : idx;
    case (digit)
      4'd0:    segs = 7'h06;
      4'd1:    segs = 7'h5B;
      4'd2:    segs = 7'h4F;
      4'd3:    segs = 7'h66;
      4'd4:    segs = 7'h6D;
      4'd5:    segs = 7'h7D;
      4'd6:    segs = 7'h07;
      default: segs = 7'h00;
    endcase
    return {mid, segs};
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises the incoming tone, detects rising edges and measures the
// spacing between them with a counter that saturates instead of wrapping.
module tone_period_meter #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 20000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tone_i,
  output logic          rise_o,
  output logic [CW-1:0] period_o,
  output logic          timeout_o
);

  logic          sync1_q, sync2_q, edge_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rise_o    = sync2_q & ~edge_q;
  assign period_o  = cnt_q;
  assign timeout_o = (cnt_q >= CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (rise_o) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(TIMEOUT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= tone_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Identifies which of 14 notes is present on tone_in by matching measured
// periods against the nominal table and locking after CONFIRM agreeing periods.
module tone_detector import tone_pkg::*; #(
  parameter int TOL     = 30,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 20000,
  parameter int CW      = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 tone_in,
  output logic                 note_valid,
  output logic [NOTE_W-1:0]    note_idx,
  output logic [NUM_NOTES-1:0] key_onehot,
  output logic                 note_strobe,
  output logic [7:0]           codeout
);

  localparam int CNT_W = (CONFIRM > 1) ? $clog2(CONFIRM + 1) : 1;

  logic                 rise_s, timeout_s;
  logic [CW-1:0]        period_s;
  logic                 match_vld_s, lock_s;
  logic [NOTE_W-1:0]    match_idx_s;
  state_e               state_q, state_d;
  logic [NOTE_W-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0]     conf_q, conf_d;
  logic                 valid_q, valid_d, strobe_q, strobe_d;
  logic [NOTE_W-1:0]    idx_q, idx_d;
  logic [NUM_NOTES-1:0] onehot_q, onehot_d;
  logic [7:0]           code_q, code_d;

  tone_period_meter #(.CW(CW), .TIMEOUT(TIMEOUT)) u_meter (
    .clk_i     (clk_in),
    .rst_i     (rst),
    .tone_i    (tone_in),
    .rise_o    (rise_s),
    .period_o  (period_s),
    .timeout_o (timeout_s)
  );

  // A saturated period never matches, even if a note window reached that far.
  function automatic logic in_window(input logic [CW-1:0] p, input logic [15:0] nom);
    logic [31:0] p32, n32;
    p32 = 32'(p);
    n32 = 32'(nom);
    return (p32 + 32'(TOL) >= n32) && (p32 <= n32 + 32'(TOL)) && (p32 < 32'(TIMEOUT));
  endfunction

  // Windows are disjoint, so the priority order only matters for robustness.
  always_comb begin
    match_vld_s = 1'b0;
    match_idx_s = '0;
    for (int n = NUM_NOTES - 1; n >= 0; n--) begin
      if (in_window(period_s, nom_period(NOTE_W'(n)))) begin
        match_vld_s = 1'b1;
        match_idx_s = NOTE_W'(n);
      end else begin
        match_vld_s = match_vld_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    conf_d  = conf_q;
    if (timeout_s && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      conf_d  = '0;
    end else if (rise_s) begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED, ST_ACQ, ST_LOCK: begin
          if (!match_vld_s) begin
            state_d = ST_ARMED;
            conf_d  = '0;
          end else if ((state_q != ST_ARMED) && (match_idx_s == cand_q)) begin
            if (state_q == ST_ACQ) begin
              conf_d  = conf_q + CNT_W'(1);
              state_d = (32'(conf_q) + 32'd1 >= 32'(CONFIRM)) ? ST_LOCK : ST_ACQ;
            end else begin
              state_d = ST_LOCK;
            end
          end else begin
            cand_d  = match_idx_s;
            conf_d  = CNT_W'(1);
            state_d = (CONFIRM <= 1) ? ST_LOCK : ST_ACQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Outputs follow the next state so they appear one cycle after the deciding rise.
  always_comb begin
    lock_s   = (state_d == ST_LOCK);
    valid_d  = lock_s;
    idx_d    = lock_s ? cand_d : '0;
    onehot_d = lock_s ? ({{(NUM_NOTES-1){1'b0}}, 1'b1} << cand_d) : '0;
    code_d   = lock_s ? seg_code(cand_d) : 8'h00;
    strobe_d = lock_s && ((state_q != ST_LOCK) || (cand_d != cand_q));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      conf_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      code_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      conf_q   <= conf_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      code_q   <= code_d;
    end
  end

  assign note_valid  = valid_q;
  assign note_idx    = idx_q;
  assign key_onehot  = onehot_q;
  assign note_strobe = strobe_q;
  assign codeout     = code_q;

endmodule
